wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of buffered write entries; SHALL be a power of two, 2..16.
REQ-002 Parameter DW, default 32, meaning data width; AW, default 5, meaning register address width.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 in_valid  input  1  execute stage offers a write; in_rd  input  AW  destination register; in_data  input  DW  write value.
REQ-006 in_ready  output  1  queue can accept an entry this cycle.
REQ-007 rf_stall  input  1  register file cannot take a write this cycle (read in progress).
REQ-008 rf_en  output  1  register file enable; rf_rw  output  1  write strobe; rf_rd  output  AW  write address; rf_data  output  DW  write data.
REQ-009 byp_rs1, byp_rs2  input  AW  source addresses being read.
REQ-010 byp_hit1, byp_hit2  output  1  pending write matches; byp_data1, byp_data2  output  DW  forwarded value.
REQ-011 count  output  log2(DEPTH)+1  occupied entries; empty  output  1  count==0.

Function
REQ-012 Queue SHALL be FIFO: writes reach the register file in acceptance order.
REQ-013 in_ready SHALL be 1 iff count<DEPTH, combinational from count only; no same-cycle push-through when full.
REQ-014 Push SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_rd/in_data captured at that edge.
REQ-015 Pop SHALL occur on a rising edge where empty=0 and rf_stall=0; popped entry loaded into output register.
REQ-016 Output register: rf_rw=1 with rf_rd/rf_data of popped entry for exactly the cycle following the pop edge; otherwise rf_rw=0, rf_rd/rf_data hold last values.
REQ-017 rf_en SHALL equal rf_rw.
REQ-018 Minimum latency: entry pushed at edge N, popped at edge N+1, rf_rw high during cycle N+1..N+2.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; both take effect; allowed when full only via pop (in_ready still 0 that cycle).
REQ-020 Read/write pointers SHALL wrap modulo DEPTH without gaps.
REQ-021 Drain rate SHALL be one entry per non-stalled cycle; rf_stall=1 holds queue and drives rf_rw=0 next cycle.
REQ-022 Bypass SHALL be combinational: byp_hitN=1 iff byp_rsN matches any valid queue entry or the output register while rf_rw=1.
REQ-023 On multiple matches byp_dataN SHALL be the newest (queue tail-most entry, then older entries, output register lowest priority).
REQ-024 byp_dataN SHALL be 0 when byp_hitN=0.
REQ-025 An incoming in_valid entry not yet accepted SHALL NOT produce a bypass hit.

Reset
REQ-026 rst=0 SHALL immediately, independent of clk: count=0, empty=1, in_ready=1, rf_en=0, rf_rw=0, rf_rd=0, rf_data=0, pointers=0, all entries invalid.
REQ-027 Reset mid-operation SHALL discard all pending entries; no rf_rw pulse after reset release until a new push.
REQ-028 First push SHALL be accepted on the first rising edge with rst=1.

Configuration
REQ-029 Macro WBQ_ZERO_DROP_EN: when defined, accepted entries with in_rd=0 SHALL be consumed (in_ready rules unchanged) but not enqueued, and byp_rsN=0 SHALL never hit.
REQ-030 Without WBQ_ZERO_DROP_EN, in_rd=0 entries SHALL be enqueued, written and bypassed like any other address.

Verification
REQ-031 Reset release, push rd=3 data=0xDEADBEEF, rf_stall=0 -> rf_rw=1, rf_rd=3, rf_data=0xDEADBEEF one cycle after pop edge; count returns 0.
REQ-032 rf_stall=1, push 4 entries rd=1..4 data=0x11..0x44 -> count=4, in_ready=0, 5th offer not accepted; release stall -> writes rd 1,2,3,4 on 4 consecutive cycles.
REQ-033 Queue holds rd=5/0xA then rd=5/0xB, byp_rs1=5, byp_rs2=6 -> byp_hit1=1, byp_data1=0xB, byp_hit2=0, byp_data2=0.
REQ-034 Full queue, rf_stall=0, in_valid=1 continuously for 12 cycles -> one pop per cycle, pointers wrap, order preserved, no loss or duplicate.
REQ-035 Three entries pending, assert rst=0 between edges -> rf_rw=0 and count=0 immediately; no write after release.
REQ-036 With WBQ_ZERO_DROP_EN, push rd=0/0x55 -> accepted, count stays 0, no rf_rw, byp_rs1=0 gives hit 0; without macro -> written to rd=0.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue: write-back buffer between the execute stage and the register file.
// Accepted writes drain in order, one per cycle while the register file is not stalled.
// Pending writes, including the one in the output register, are forwarded to two read ports.
// Optional feature macro: WBQ_ZERO_DROP_EN. When it is defined, writes to register 0 are
// accepted but discarded, and reads of register 0 never get a forwarding hit.
module wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [AW-1:0]            in_rd,
    input  logic [DW-1:0]            in_data,
    output logic                     in_ready,
    input  logic                     rf_stall,
    output logic                     rf_en,
    output logic                     rf_rw,
    output logic [AW-1:0]            rf_rd,
    output logic [DW-1:0]            rf_data,
    input  logic [AW-1:0]            byp_rs1,
    input  logic [AW-1:0]            byp_rs2,
    output logic                     byp_hit1,
    output logic                     byp_hit2,
    output logic [DW-1:0]            byp_data1,
    output logic [DW-1:0]            byp_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AW-1:0] mem_rd   [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];

    logic push_c;
    logic pop_c;
    logic enq_c;
    logic keep_c;

    // Queue status, derived from the occupancy count alone
    assign empty    = (count == '0);
    assign in_ready = (count < CW'(DEPTH));

    // Handshake decode
    assign push_c = in_valid & in_ready;
    assign pop_c  = ~empty & ~rf_stall;
`ifdef WBQ_ZERO_DROP_EN
    assign keep_c = (in_rd != '0);
`else
    assign keep_c = 1'b1;
`endif
    assign enq_c  = push_c & keep_c;

    // Occupancy and pointers; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c) rd_ptr <= rd_ptr + PW'(1);
            case ({enq_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; validity is implied by the pointers and count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_rd[i]   <= '0;
                mem_data[i] <= '0;
            end
        end else if (enq_c) begin
            mem_rd[wr_ptr]   <= in_rd;
            mem_data[wr_ptr] <= in_data;
        end
    end

    // Output register: one-cycle write strobe per popped entry, address/data held otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_rw   <= 1'b0;
            rf_en   <= 1'b0;
            rf_rd   <= '0;
            rf_data <= '0;
        end else begin
            rf_rw <= pop_c;
            rf_en <= pop_c;
            if (pop_c) begin
                rf_rd   <= mem_rd[rd_ptr];
                rf_data <= mem_data[rd_ptr];
            end
        end
    end

    // Forwarding lookup: scan oldest to newest so the newest match wins,
    // with the output register as the lowest-priority source
    function automatic logic [DW:0] byp_lookup(input logic [AW-1:0] rs);
        logic          hit;
        logic [DW-1:0] data;
        logic [PW-1:0] idx;
        hit  = rf_rw && (rf_rd == rs);
        data = rf_data;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (mem_rd[idx] == rs)) begin
                hit  = 1'b1;
                data = mem_data[idx];
            end
        end
`ifdef WBQ_ZERO_DROP_EN
        if (rs == '0) hit = 1'b0;
`endif
        if (!hit) data = '0;
        return {hit, data};
    endfunction

    // Combinational bypass for both read ports
    always_comb begin
        {byp_hit1, byp_data1} = byp_lookup(byp_rs1);
        {byp_hit2, byp_data2} = byp_lookup(byp_rs2);
    end

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_wb_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [AW-1:0] in_rd = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          rf_stall = 1'b0;
    logic          rf_en;
    logic          rf_rw;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_data;
    logic [AW-1:0] byp_rs1 = '0;
    logic [AW-1:0] byp_rs2 = '0;
    logic          byp_hit1;
    logic          byp_hit2;
    logic [DW-1:0] byp_data1;
    logic [DW-1:0] byp_data2;
    logic [CW-1:0] count;
    logic          empty;

    wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_rd(in_rd), .in_data(in_data), .in_ready(in_ready),
        .rf_stall(rf_stall), .rf_en(rf_en), .rf_rw(rf_rw), .rf_rd(rf_rd), .rf_data(rf_data),
        .byp_rs1(byp_rs1), .byp_rs2(byp_rs2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pending writes in acceptance order plus the register-file port
    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic          m_rw   = 1'b0;
    logic [AW-1:0] m_rd   = '0;
    logic [DW-1:0] m_data = '0;

    function automatic bit keep(input logic [AW-1:0] rd);
`ifdef WBQ_ZERO_DROP_EN
        return rd != '0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_byp(input logic [AW-1:0] rs, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (!keep(rs)) return;
        for (int i = int'(q.size()) - 1; i >= 0; i--) begin
            if (q[i].rd == rs) begin
                hit = 1'b1;
                d   = q[i].d;
                return;
            end
        end
        if (m_rw && m_rd == rs) begin
            hit = 1'b1;
            d   = m_data;
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_rw   = 1'b0;
        m_rd   = '0;
        m_data = '0;
    endfunction

    task automatic check_comb();
        logic          h;
        logic [DW-1:0] d;
        check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
        model_byp(byp_rs1, h, d);
        check("byp_hit1", 64'(byp_hit1), 64'(h));
        check("byp_data1", 64'(byp_data1), 64'(d));
        model_byp(byp_rs2, h, d);
        check("byp_hit2", 64'(byp_hit2), 64'(h));
        check("byp_data2", 64'(byp_data2), 64'(d));
    endtask

    task automatic check_regs();
        check("count", 64'(count), 64'(q.size()));
        check("empty", 64'(empty), 64'(q.size() == 0));
        check("rf_rw", 64'(rf_rw), 64'(m_rw));
        check("rf_en", 64'(rf_en), 64'(m_rw));
        check("rf_rd", 64'(rf_rd), 64'(m_rd));
        check("rf_data", 64'(rf_data), 64'(m_data));
    endtask

    // Drive inputs just after a falling edge, then check combinational outputs
    task automatic drive(input logic iv, input logic [AW-1:0] rd, input logic [DW-1:0] data,
                         input logic stall, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        in_valid = iv;
        in_rd    = rd;
        in_data  = data;
        rf_stall = stall;
        byp_rs1  = rs1;
        byp_rs2  = rs2;
        #1;
        check_comb();
    endtask

    // Advance one clock: update the model at the rising edge, check registers at the falling edge
    task automatic tick();
        bit   push;
        bit   pop;
        ent_t e;
        @(posedge clk);
        push = in_valid && (q.size() < DEPTH);
        pop  = (q.size() > 0) && !rf_stall;
        e.rd = in_rd;
        e.d  = in_data;
        m_rw = pop;
        if (pop) begin
            m_rd   = q[0].rd;
            m_data = q[0].d;
            void'(q.pop_front());
        end
        if (push && keep(e.rd)) q.push_back(e);
        @(negedge clk);
        check_regs();
    endtask

    initial begin
        model_reset();
        #2;
        check_regs();
        check_comb();

        @(negedge clk);
        rst = 1'b1;

        // Single write through the queue
        drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd3, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd7);
        tick();
        check("w1_rd", 64'(rf_rd), 64'd3);
        check("w1_data", 64'(rf_data), 64'hDEADBEEF);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd7);
        tick();

        // Fill under stall, refuse a fifth offer, then drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, AW'(i), DW'(i * 32'h11), 1'b1, 5'd2, 5'd4);
            tick();
        end
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd1);
        check("full_ready", 64'(in_ready), 64'd0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd1);
            tick();
            check("drain_rd", 64'(rf_rd), 64'(i));
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd1);
        tick();

        // Newest match wins on bypass
        drive(1'b1, 5'd5, 32'hA, 1'b1, 5'd5, 5'd6);
        tick();
        drive(1'b1, 5'd5, 32'hB, 1'b1, 5'd5, 5'd6);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd6);
        check("byp_newest", 64'(byp_data1), 64'hB);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd6);
            tick();
        end

        // Full queue with continuous offers: one pop per cycle across pointer wrap
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, AW'(10 + i), $urandom, 1'b1, AW'(10 + i), 5'd12);
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, AW'(16 + i), $urandom, 1'b0, AW'(16 + i), AW'(15 + i));
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd20, 5'd27);
            tick();
        end

        // Reset between edges discards pending entries
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, AW'(7 + i), $urandom, 1'b1, 5'd7, 5'd8);
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd8);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_regs();
        check_comb();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd9);
            tick();
        end

        // Writes to register 0
        drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 5'd1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1);
        tick();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'(($urandom % 4) != 0), AW'($urandom_range(0, 7)), $urandom,
                  1'(($urandom % 10) < 3), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
